// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx round-robin arbiter: FSM encoding,
// default data width and timeout counter width.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } arb_state_e;

   localparam int DEF_DWIDTH = 8;
   localparam int TMO_CW     = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle: NREQ byte producers presenting valid/data/parity
// and receiving a one-hot accept pulse.
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = DEF_DWIDTH
);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DWIDTH-1:0] req_data;
   logic [NREQ-1:0]        req_parity_en;
   logic [NREQ-1:0]        req_parity_type;
   logic [NREQ-1:0]        req_ready;

   modport master (
      output req_valid, req_data, req_parity_en, req_parity_type,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_data, req_parity_en, req_parity_type,
      output req_ready
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ    = 4,
   parameter int IDWIDTH = 2
) (
   input  logic [NREQ-1:0]    req_valid,
   input  logic [IDWIDTH-1:0] ptr,
   output logic [IDWIDTH-1:0] sel,
   output logic               any
);

   logic [2*NREQ-1:0] doubled;
   logic [NREQ-1:0]   rotated;
   int                pos;

   // Rotate so bit 0 is the pointer position, then take the lowest set bit.
   always_comb begin
      doubled = {req_valid, req_valid};
      rotated = NREQ'(doubled >> ptr);
      any     = |req_valid;
      pos     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rotated[k]) pos = int'(ptr) + k;
      end
      if (pos >= NREQ) pos = pos - NREQ;
      sel = IDWIDTH'(pos);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ producers: round-robin accept, one-cycle
// issue pulse, then tracks tx_busy for completion or timeout.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DWIDTH  = DEF_DWIDTH,
   parameter int IDWIDTH = 2,
   parameter int TMO_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_arbiter_if.slave    req_bus,
   output logic [DWIDTH-1:0]   tx_p_data,
   output logic                tx_data_valid,
   output logic                tx_parity_en,
   output logic                tx_parity_type,
   input  logic                tx_busy,
   output logic [IDWIDTH-1:0]  grant_id,
   output logic                done,
   output logic                err_tmo
);

   localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'(TMO_CYC - 1);

   arb_state_e         state, state_nxt;
   logic [IDWIDTH-1:0] rr_ptr;
   logic [IDWIDTH-1:0] sel;
   logic               any_valid;
   logic               accept;
   logic [NREQ-1:0]    ready_c;
   logic [TMO_CW-1:0]  tmo_cnt;

   rr_pick #(.NREQ(NREQ), .IDWIDTH(IDWIDTH)) u_pick (
      .req_valid (req_bus.req_valid),
      .ptr       (rr_ptr),
      .sel       (sel),
      .any       (any_valid)
   );

   assign req_bus.req_ready = ready_c;

   // Pulses are decoded from the current state so accept, issue, done and
   // timeout land in the cycle the condition is seen; reset masks them.
   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      ready_c       = '0;
      tx_data_valid = 1'b0;
      done          = 1'b0;
      err_tmo       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!tx_busy && any_valid) begin
               accept    = 1'b1;
               ready_c   = NREQ'(1) << sel;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tx_data_valid = 1'b1;
            state_nxt     = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_DONE;
            end else if (tmo_cnt == TMO_LAST) begin
               err_tmo   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (rst) begin
         accept        = 1'b0;
         ready_c       = '0;
         tx_data_valid = 1'b0;
         done          = 1'b0;
         err_tmo       = 1'b0;
      end
   end

   // Frame registers only move on accept, so the transmitter and grant_id
   // see stable values for the whole frame including the done cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         rr_ptr         <= '0;
         tmo_cnt        <= '0;
         tx_p_data      <= '0;
         tx_parity_en   <= 1'b0;
         tx_parity_type <= 1'b0;
         grant_id       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            tx_p_data      <= DWIDTH'(req_bus.req_data >> (int'(sel) * DWIDTH));
            tx_parity_en   <= |(req_bus.req_parity_en & ready_c);
            tx_parity_type <= |(req_bus.req_parity_type & ready_c);
            grant_id       <= sel;
            rr_ptr         <= (sel == IDWIDTH'(NREQ - 1)) ? '0 : sel + 1'b1;
         end
         if (state == S_ISSUE) begin
            tmo_cnt <= '0;
         end else if (state == S_WAIT_BUSY && !tx_busy) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx instance between NREQ byte producers, each with its own parity settings.
- Accepts one byte per valid/ready handshake and drives the transmitter's p_data / data_valid / parity inputs.
- Tracks the transmitter's busy flag to sequence frames back to back, and reports completion or timeout per frame.
- Sits between the requesters (command engine, status reporter, debug port, …) and the uart top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 8, data width; must match uart_tx DWIDTH.
- IDWIDTH, 2, requester-index width; must be at least clog2(NREQ).
- TMO_CYC, 16, max cycles to wait for tx_busy to rise after issue (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester byte available.
- req_data  input  NREQ*DWIDTH  flattened bytes; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_parity_en  input  NREQ  per-requester parity enable.
- req_parity_type  input  NREQ  per-requester parity type.
- req_ready  output  NREQ  one-hot, single-cycle accept pulse.
- tx_p_data  output  DWIDTH  to uart_tx p_data.
- tx_data_valid  output  1  to uart_tx data_valid; single-cycle pulse.
- tx_parity_en  output  1  to uart_tx parity_en.
- tx_parity_type  output  1  to uart_tx parity_type.
- tx_busy  input  1  from uart_tx busy.
- grant_id  output  IDWIDTH  index of the requester owning the current frame.
- done  output  1  single-cycle pulse when a frame completes.
- err_tmo  output  1  single-cycle pulse when tx_busy fails to rise within TMO_CYC.

Behaviour:
- Reset: every output is 0, state is IDLE, RR pointer is 0, timeout counter is 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE
  - Acts only when tx_busy=0 and any req_valid=1.
  - Selects the first valid index scanning from the RR pointer upward, wrapping modulo NREQ.
  - Same cycle: req_ready[sel]=1. Latches data and parity bits into the tx_* registers, and sel into grant_id.
  - Sets RR pointer to (sel+1) mod NREQ, then goes to ISSUE.
  - If tx_busy=1 (external or residual), no grant is made and the FSM stays in IDLE.
- ISSUE
  - tx_data_valid=1 for exactly this one cycle.
  - Clears the timeout counter, then goes to WAIT_BUSY.
- WAIT_BUSY
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches TMO_CYC-1 with tx_busy still 0: err_tmo=1 for one cycle, then IDLE with no done pulse.
  - The RR pointer is not rewound on timeout; the byte is considered dropped.
- WAIT_DONE
  - tx_busy falls to 0 -> done=1 for one cycle, then IDLE.
  - grant_id stays valid in the done cycle.
- Stability: tx_p_data, tx_parity_en, tx_parity_type and grant_id are held constant from the accept cycle until the next accept. They change only on accept or reset.
- Latency:
  - Accept to tx_data_valid: 1 cycle.
  - tx_busy falling to done: 1 cycle.
  - done to the next possible accept: 1 cycle, since IDLE evaluates on the cycle after done.
- Requests
  - req_valid may drop at any time before accept with no effect.
  - A request is consumed only by its req_ready pulse.
  - Data is sampled only in the accept cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…; no requester waits more than NREQ-1 frames.
- Single active requester: granted on every frame regardless of pointer position.
- Reset mid-frame: returns to IDLE and clears outputs. The in-flight byte is lost; uart_tx shares rst.

Decomposition:
- Shared package/include (uart_defs):
  - FSM state encodings (2 bits).
  - Default DWIDTH.
  - TMO counter width constant (8).
- One sub-module: rr_pick, a combinational round-robin selector with inputs req_valid and ptr, outputs sel and any.
- The FSM, counters and data registers stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=4'b0100, data[2]=8'hA5, parity_en=1, type=1; busy rises 2 cycles after issue and falls 10 cycles later.
  -> req_ready=4'b0100 for 1 cycle; next cycle tx_data_valid=1 with tx_p_data=A5, parity 1/1.
  -> done pulses 1 cycle after busy falls; grant_id=2.
- All four valid continuously, bytes 10/11/12/13, busy model 5 cycles per frame.
  -> 8 frames granted in order 0,1,2,3,0,1,2,3; each tx_data_valid is exactly 1 cycle.
- Pointer wrap: after a grant to 3, only req 1 and req 3 valid -> next grant is 1; after that, next grant is 3.
- Timeout: tx_busy held 0 after issue -> err_tmo pulses exactly 16 cycles after tx_data_valid, done never pulses, FSM returns to IDLE and accepts the next request.
- External busy: tx_busy=1 while in IDLE with req_valid=4'b0001 -> no req_ready while busy; grant occurs on the first cycle tx_busy is low.
- Reset mid-frame: assert rst during WAIT_DONE -> next cycle all outputs 0; after release, the first grant goes to requester 0 (pointer reset).
